// File: rtl/rr_arb32_idx_pkg.sv
// Shared constants and types for the 32-way round-robin index arbiter.
package rr_arb32_idx_pkg;

    localparam int unsigned ARB_IDX_W   = 5;
    localparam int unsigned ARB_N_REQ   = 1 << ARB_IDX_W;
    localparam int unsigned ARB_PTR_RST = 0;

    typedef logic [ARB_IDX_W-1:0] idx_t;
    typedef logic [ARB_N_REQ-1:0] req_t;

endpackage

// File: rtl/rr_arb32_idx_prienc32.sv
// Lowest-set-bit priority encoder: 32-bit vector in, 5-bit index and any-set flag out.
module prienc32 (
    input  logic [31:0] vec,
    output logic [4:0]  idx,
    output logic        any
);

    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (!any && vec[i]) begin
                idx = 5'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arb32_idx.sv
// Round-robin arbiter over 32 requests with a registered winner index and valid/ready handshake.
// Optional burst lock input enabled by defining RR_ARB_LOCK_EN.
module rr_arb32_idx
    import rr_arb32_idx_pkg::*;
#(
    parameter int unsigned IDX_W   = ARB_IDX_W,
    parameter int unsigned PTR_RST = ARB_PTR_RST
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [(1<<IDX_W)-1:0]   req,
`ifdef RR_ARB_LOCK_EN
    input  logic                    lock,
`endif
    input  logic                    gnt_rdy,
    output logic                    gnt_vld,
    output logic [IDX_W-1:0]        gnt_idx,
    output logic                    busy
);

    localparam int unsigned      N_REQ    = 1 << IDX_W;
    localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(PTR_RST);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] off;
    logic [IDX_W-1:0] sel;
    logic [N_REQ-1:0] rot;
    logic             any;
    logic             load;
    logic             hold;

    assign busy = |req;
    assign load = !gnt_vld || gnt_rdy;

    // Doubling the vector makes the right-rotate by ptr a plain shift, including ptr == 0.
    assign rot = N_REQ'({req, req} >> ptr);

    prienc32 u_enc (
        .vec (rot),
        .idx (off),
        .any (any)
    );

    assign sel = ptr + off;

`ifdef RR_ARB_LOCK_EN
    assign hold = gnt_vld && lock && req[gnt_idx];
`else
    assign hold = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_vld <= 1'b0;
            gnt_idx <= '0;
            ptr     <= PTR_INIT;
        end else if (load) begin
            if (hold) begin
                // Locked burst: re-present the same winner, pointer stays put.
                gnt_vld <= 1'b1;
            end else if (any) begin
                gnt_vld <= 1'b1;
                gnt_idx <= sel;
                ptr     <= sel + IDX_W'(1);
            end else begin
                gnt_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_arb32_idx.sv
// Self-checking bench for rr_arb32_idx: vector table plus hand sequences for reset and lock.
module tb_rr_arb32_idx;

    typedef struct {
        logic [31:0] req;
        logic        rdy;
        logic        vld;
        logic [4:0]  idx;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] req;
    logic        gnt_rdy;
    logic        gnt_vld;
    logic [4:0]  gnt_idx;
    logic        busy;
`ifdef RR_ARB_LOCK_EN
    logic        lock;
`endif

    int unsigned chk_cnt  = 0;
    int unsigned pass_cnt = 0;
    logic [5:0]  exp_q[$];
    vec_t        tbl[$];

    always #5 clk = ~clk;

    rr_arb32_idx #(
        .IDX_W   (5),
        .PTR_RST (0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
`ifdef RR_ARB_LOCK_EN
        .lock    (lock),
`endif
        .gnt_rdy (gnt_rdy),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx),
        .busy    (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Drive one cycle of stimulus, queue the expected post-edge outputs, then compare after the edge.
    task automatic apply(input logic [31:0] r, input logic rd, input logic ev,
                         input logic [4:0] ei, input string name);
        logic [5:0] e;
        req     = r;
        gnt_rdy = rd;
        exp_q.push_back({ev, ei});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check(name, {26'd0, gnt_vld, gnt_idx}, {26'd0, e});
            check({name, "_busy"}, {31'd0, busy}, {31'd0, |r});
        end
    endtask

    task automatic add(input logic [31:0] r, input logic rd, input logic ev,
                       input logic [4:0] ei, input string name);
        vec_t v;
        v.req = r; v.rdy = rd; v.vld = ev; v.idx = ei; v.name = name;
        tbl.push_back(v);
    endtask

    initial begin
        // All requests: strict rotation 0..31 then wrap to 0; ptr ends at 1.
        for (int i = 0; i < 33; i++) add(32'hFFFF_FFFF, 1'b1, 1'b1, 5'(i % 32), "all_req");
        // Two ends of the vector from ptr=1: 31 first, then wrap to 0.
        add(32'h8000_0001, 1'b1, 1'b1, 5'd31, "ends_31a");
        add(32'h8000_0001, 1'b1, 1'b1, 5'd0,  "ends_0a");
        add(32'h8000_0001, 1'b1, 1'b1, 5'd31, "ends_31b");
        add(32'h8000_0001, 1'b1, 1'b1, 5'd0,  "ends_0b");
        add(32'h0,         1'b1, 1'b0, 5'd0,  "drain1");
        // Stall: grant 4 held while req moves to bit 8, then accept gives 8.
        add(32'h0000_0010, 1'b0, 1'b1, 5'd4,  "stall_grant");
        for (int i = 0; i < 3; i++) add(32'h0000_0100, 1'b0, 1'b1, 5'd4, "stall_hold");
        add(32'h0000_0100, 1'b1, 1'b1, 5'd8,  "stall_next");
        add(32'h0,         1'b1, 1'b0, 5'd8,  "drain2");
        // Single requester below the pointer: granted every accept.
        for (int i = 0; i < 3; i++) add(32'h0000_0020, 1'b1, 1'b1, 5'd5, "single");
        add(32'h0,         1'b1, 1'b0, 5'd5,  "drain3");

        rst = 1'b0; req = '0; gnt_rdy = 1'b0;
`ifdef RR_ARB_LOCK_EN
        lock = 1'b0;
`endif
        #1 rst = 1'b1;
        #2;
        check("rst_out", {26'd0, gnt_vld, gnt_idx}, 32'd0);
        check("rst_busy0", {31'd0, busy}, 32'd0);
        req = 32'h10;
        #1;
        check("rst_busy1", {31'd0, busy}, 32'd1);
        req = '0;
        #19 rst = 1'b0;

        for (int i = 0; i < 5; i++) apply(32'h0, 1'b1, 1'b0, 5'd0, "idle");
        foreach (tbl[i]) apply(tbl[i].req, tbl[i].rdy, tbl[i].vld, tbl[i].idx, tbl[i].name);

        // Reset mid-stall drops the pending grant without a clock edge; ptr returns to 0.
        apply(32'h0000_0010, 1'b0, 1'b1, 5'd4, "pre_rst");
        #2 rst = 1'b1;
        #1;
        check("async_rst", {26'd0, gnt_vld, gnt_idx}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd1);
        req = 32'h6; gnt_rdy = 1'b1;
        #3 rst = 1'b0;
        apply(32'h0000_0006, 1'b1, 1'b1, 5'd1, "post_rst_1");
        apply(32'h0000_0006, 1'b1, 1'b1, 5'd2, "post_rst_2");
        apply(32'h0,         1'b1, 1'b0, 5'd2, "post_rst_idle");

`ifdef RR_ARB_LOCK_EN
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        lock = 1'b1;
        apply(32'h0000_000C, 1'b1, 1'b1, 5'd2, "lock_first");
        apply(32'h0000_000C, 1'b1, 1'b1, 5'd2, "lock_hold1");
        apply(32'h0000_000C, 1'b1, 1'b1, 5'd2, "lock_hold2");
        lock = 1'b0;
        apply(32'h0000_000C, 1'b1, 1'b1, 5'd3, "unlock_3");
        apply(32'h0000_000C, 1'b1, 1'b1, 5'd2, "unlock_2");
        lock = 1'b1;
        apply(32'h0000_0008, 1'b1, 1'b1, 5'd3, "lock_norq");
        lock = 1'b0;
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
